// File: rtl/plic_claim_agent_if.sv
`default_nettype none
// ============================================================================
//  Module   : plic_claim_agent_if
//  Brief    : 32-bit address / 32-bit data register bus, single outstanding beat
//  Revision : 1.0  initial release
// ============================================================================
interface plic_claim_agent_if;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
    logic [31:0] rdata;
    logic        error;
    logic        ready;

    modport master (
        output addr, write, wdata, wstrb, valid,
        input  rdata, error, ready
    );

    modport slave (
        input  addr, write, wdata, wstrb, valid,
        output rdata, error, ready
    );
endinterface
`default_nettype wire

// File: rtl/plic_claim_agent.sv
`default_nettype none
// ============================================================================
//  Module   : plic_claim_agent
//  Brief    : PLIC claim/complete initiator: claims an ID on eip, hands it to a
//             local consumer, and writes it back once the consumer is done.
//  Revision : 1.0  initial release
// ============================================================================
module plic_claim_agent #(
    parameter int          N_SOURCE   = 30,
    parameter int          SRCW       = $clog2(N_SOURCE + 1),
    parameter logic [31:0] BASE_ADDR  = 32'h0C00_0000,
    parameter logic [31:0] CC_OFFSET  = 32'h0020_0004,
    parameter logic [31:0] CTX_STRIDE = 32'h0000_1000,
    parameter int          TARGET_ID  = 0,
    parameter int          HOLDOFF    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                eip_i,
    plic_claim_agent_if.master  reg_bus,
    output logic                irq_valid_o,
    input  logic                irq_ready_i,
    output logic [SRCW-1:0]     irq_id_o,
    input  logic                done_i,
    output logic                busy_o,
    output logic                err_o,
    output logic [15:0]         spurious_cnt_o
);

    localparam int          c_HW        = $clog2(HOLDOFF + 1);
    localparam logic [c_HW-1:0] c_HOLDOFF = c_HW'(HOLDOFF);
    localparam logic [31:0] c_NSRC      = 32'(N_SOURCE);
    // Context address wraps modulo 2^32 by construction of the 32-bit sum.
    localparam logic [31:0] c_CC_ADDR   = BASE_ADDR + CC_OFFSET + (CTX_STRIDE * 32'(TARGET_ID));

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CLAIM     = 3'd1;
    localparam logic [2:0] c_DELIVER   = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_COMPLETE  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [SRCW-1:0] r_irq_id;
    logic [c_HW-1:0] r_holdoff;
    logic            r_err;
    logic [15:0]     r_spur;

    logic [SRCW-1:0] w_rd_id;
    logic            w_rd_bad;
    logic            w_rd_spur;
    logic            w_rd_ok;
    logic            w_claim_beat;
    logic            w_cmpl_beat;

    // Any nonzero bit above the ID field also makes rdata exceed N_SOURCE.
    assign w_rd_id      = reg_bus.rdata[SRCW-1:0];
    assign w_rd_bad     = reg_bus.error || (reg_bus.rdata > c_NSRC);
    assign w_rd_spur    = !w_rd_bad && (reg_bus.rdata == 32'd0);
    assign w_rd_ok      = !w_rd_bad && !w_rd_spur;
    assign w_claim_beat = (r_state == c_CLAIM) && reg_bus.ready;
    assign w_cmpl_beat  = (r_state == c_COMPLETE) && reg_bus.ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if ((r_holdoff == '0) && eip_i) begin
                    w_next_state = c_CLAIM;
                end
            end
            c_CLAIM: begin
                if (reg_bus.ready) begin
                    w_next_state = w_rd_ok ? c_DELIVER : c_IDLE;
                end
            end
            c_DELIVER: begin
                if (irq_ready_i) begin
                    w_next_state = c_WAIT_DONE;
                end
            end
            c_WAIT_DONE: begin
                if (done_i) begin
                    w_next_state = c_COMPLETE;
                end
            end
            c_COMPLETE: begin
                if (reg_bus.ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Request fields are a pure function of state, so they hold until the beat ends.
    always_comb begin
        irq_valid_o     = (r_state == c_DELIVER);
        busy_o          = (r_state != c_IDLE);
        reg_bus.valid   = (r_state == c_CLAIM) || (r_state == c_COMPLETE);
        reg_bus.addr    = 32'd0;
        reg_bus.write   = 1'b0;
        reg_bus.wdata   = 32'd0;
        reg_bus.wstrb   = 4'h0;
        if (r_state == c_CLAIM) begin
            reg_bus.addr = c_CC_ADDR;
        end else if (r_state == c_COMPLETE) begin
            reg_bus.addr  = c_CC_ADDR;
            reg_bus.write = 1'b1;
            reg_bus.wdata = 32'(r_irq_id);
            reg_bus.wstrb = 4'hF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_id  <= '0;
            r_holdoff <= '0;
            r_err     <= 1'b0;
            r_spur    <= 16'd0;
        end else begin
            r_err <= (w_claim_beat && w_rd_bad) || (w_cmpl_beat && reg_bus.error);

            if (w_claim_beat && w_rd_ok) begin
                r_irq_id <= w_rd_id;
            end

            if (w_claim_beat && w_rd_spur && (r_spur != 16'hFFFF)) begin
                r_spur <= r_spur + 16'd1;
            end

            // Gives the PLIC time to drop eip for the source just handled.
            if ((w_claim_beat && !w_rd_ok) || w_cmpl_beat) begin
                r_holdoff <= c_HOLDOFF;
            end else if ((r_state == c_IDLE) && (r_holdoff != '0)) begin
                r_holdoff <= r_holdoff - c_HW'(1);
            end
        end
    end

    assign irq_id_o       = r_irq_id;
    assign err_o          = r_err;
    assign spurious_cnt_o = r_spur;

endmodule
`default_nettype wire
